// File: rtl/pipe_defs.sv
// Shared pipeline definitions for the RV64 5-stage core: datapath widths,
// ALU operation classes, ALU function codes and the decoded-control bundle.
package pipe_defs;

   localparam int XLEN   = 64;
   localparam int REG_AW = 5;

   // ALU operation class produced by decode and consumed by ALU control.
   typedef enum logic [1:0] {
      ALUOP_MEM    = 2'b00,  // load/store address add
      ALUOP_BRANCH = 2'b01,  // branch compare subtract
      ALUOP_RTYPE  = 2'b10,  // register-register, function from funct
      ALUOP_ITYPE  = 2'b11   // register-immediate, function from funct
   } alu_op_e;

   // {funct7[5], funct3} as seen by ALU control.
   typedef enum logic [3:0] {
      FUNCT_ADD  = 4'b0000,
      FUNCT_SUB  = 4'b1000,
      FUNCT_SLL  = 4'b0001,
      FUNCT_SLT  = 4'b0010,
      FUNCT_SLTU = 4'b0011,
      FUNCT_XOR  = 4'b0100,
      FUNCT_SRL  = 4'b0101,
      FUNCT_SRA  = 4'b1101,
      FUNCT_OR   = 4'b0110,
      FUNCT_AND  = 4'b0111
   } funct_e;

   // Decoded control carried down the pipe; all-zero is a bubble.
   typedef struct packed {
      logic    reg_write;
      logic    mem_read;
      logic    mem_write;
      logic    mem_to_reg;
      logic    branch;
      logic    alu_src;
      alu_op_e alu_op;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage : pipe_defs

// File: rtl/id_hazard_unit.sv
// Combinational ID-stage helper: WB-to-ID operand bypass for the register
// file read ports, and load-use hazard detection against the EX slot.
module id_hazard_unit #(
   parameter int XLEN   = pipe_defs::XLEN,
   parameter int REG_AW = pipe_defs::REG_AW
) (
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [XLEN-1:0]   Read_Data_1,
   input  logic [XLEN-1:0]   Read_Data_2,
   input  logic              wb_RegWrite,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [XLEN-1:0]   wb_Write_Data,
   input  logic              ex_valid,
   input  logic              ex_MemRead,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_flush,
   output logic [XLEN-1:0]   op1,
   output logic [XLEN-1:0]   op2,
   output logic              stall
);

   logic rs1_dep;
   logic rs2_dep;
   logic hz;

   // Operand select: x0 is hard zero, a same-cycle WB write wins over the
   // (not yet updated) register file, otherwise the register file data.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can
      // leave it unassigned and infer a latch.
      op1 = Read_Data_1;
      op2 = Read_Data_2;
      if (id_rs1 == '0) begin
         op1 = '0;
      end else if (wb_RegWrite && (wb_rd == id_rs1)) begin
         op1 = wb_Write_Data;
      end
      if (id_rs2 == '0) begin
         op2 = '0;
      end else if (wb_RegWrite && (wb_rd == id_rs2)) begin
         op2 = wb_Write_Data;
      end
   end

   // A load in EX whose destination is actually read by the ID instruction.
   // The WB bypass cannot cover this: the load data does not exist yet.
   assign rs1_dep = id_use_rs1 && (ex_rd == id_rs1);
   assign rs2_dep = id_use_rs2 && (ex_rd == id_rs2);
   assign hz      = id_valid && ex_valid && ex_MemRead && (ex_rd != '0)
                    && (rs1_dep || rs2_dep);

   // A flush squashes the ID instruction anyway, so there is nothing to hold.
   assign stall = hz && !ex_flush;

endmodule : id_hazard_unit

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the RV64 5-stage core. Captures bypassed
// operands, immediate, register indices and decoded control; inserts
// bubbles on flush, load-use stall and empty ID slot; counts stall and
// flush events with saturating counters.
module id_ex_stage #(
   parameter int XLEN   = pipe_defs::XLEN,
   parameter int REG_AW = pipe_defs::REG_AW,
   parameter int CNT_W  = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [XLEN-1:0]   id_pc,
   input  logic [XLEN-1:0]   Read_Data_1,
   input  logic [XLEN-1:0]   Read_Data_2,
   input  logic [XLEN-1:0]   id_imm,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [3:0]        id_funct,
   input  logic              id_RegWrite,
   input  logic              id_MemRead,
   input  logic              id_MemWrite,
   input  logic              id_MemtoReg,
   input  logic              id_Branch,
   input  logic              id_ALUSrc,
   input  logic [1:0]        id_ALUOp,
   input  logic              wb_RegWrite,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [XLEN-1:0]   wb_Write_Data,
   input  logic              ex_flush,
   output logic              stall,
   output logic              ex_valid,
   output logic [XLEN-1:0]   ex_pc,
   output logic [XLEN-1:0]   ex_op1,
   output logic [XLEN-1:0]   ex_op2,
   output logic [XLEN-1:0]   ex_imm,
   output logic [REG_AW-1:0] ex_rs1,
   output logic [REG_AW-1:0] ex_rs2,
   output logic [REG_AW-1:0] ex_rd,
   output logic [3:0]        ex_funct,
   output logic              ex_RegWrite,
   output logic              ex_MemRead,
   output logic              ex_MemWrite,
   output logic              ex_MemtoReg,
   output logic              ex_Branch,
   output logic              ex_ALUSrc,
   output logic [1:0]        ex_ALUOp,
   output logic [CNT_W-1:0]  stall_count,
   output logic [CNT_W-1:0]  flush_count
);

   import pipe_defs::*;

   logic [XLEN-1:0] op1_byp;
   logic [XLEN-1:0] op2_byp;
   ctrl_t           id_ctrl;
   ctrl_t           ex_ctrl_q;
   logic            bubble;

   id_hazard_unit #(
      .XLEN   (XLEN),
      .REG_AW (REG_AW)
   ) u_hazard (
      .id_valid      (id_valid),
      .id_rs1        (id_rs1),
      .id_rs2        (id_rs2),
      .id_use_rs1    (id_use_rs1),
      .id_use_rs2    (id_use_rs2),
      .Read_Data_1   (Read_Data_1),
      .Read_Data_2   (Read_Data_2),
      .wb_RegWrite   (wb_RegWrite),
      .wb_rd         (wb_rd),
      .wb_Write_Data (wb_Write_Data),
      .ex_valid      (ex_valid),
      .ex_MemRead    (ex_ctrl_q.mem_read),
      .ex_rd         (ex_rd),
      .ex_flush      (ex_flush),
      .op1           (op1_byp),
      .op2           (op2_byp),
      .stall         (stall)
   );

   assign id_ctrl = '{
      reg_write:  id_RegWrite,
      mem_read:   id_MemRead,
      mem_write:  id_MemWrite,
      mem_to_reg: id_MemtoReg,
      branch:     id_Branch,
      alu_src:    id_ALUSrc,
      alu_op:     alu_op_e'(id_ALUOp)
   };

   // Flush, stall and an empty ID slot all turn the EX slot into a bubble.
   assign bubble = ex_flush || stall || !id_valid;

   // ID/EX register: a bubble clears only valid and control; the datapath
   // fields hold since nothing downstream looks at them while ex_valid=0.
   always_ff @(posedge clock or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!reset) begin
         // NOTE: datapath fields are reset too so every EX output reads a
         // defined zero while reset is held, not just the valid/control bits.
         ex_valid  <= 1'b0;
         ex_ctrl_q <= CTRL_BUBBLE;
         ex_pc     <= '0;
         ex_op1    <= '0;
         ex_op2    <= '0;
         ex_imm    <= '0;
         ex_rs1    <= '0;
         ex_rs2    <= '0;
         ex_rd     <= '0;
         ex_funct  <= '0;
      end else if (bubble) begin
         ex_valid  <= 1'b0;
         ex_ctrl_q <= CTRL_BUBBLE;
      end else begin
         ex_valid  <= 1'b1;
         ex_ctrl_q <= id_ctrl;
         ex_pc     <= id_pc;
         ex_op1    <= op1_byp;
         ex_op2    <= op2_byp;
         ex_imm    <= id_imm;
         ex_rs1    <= id_rs1;
         ex_rs2    <= id_rs2;
         ex_rd     <= id_rd;
         ex_funct  <= id_funct;
      end
   end

   assign ex_RegWrite = ex_ctrl_q.reg_write;
   assign ex_MemRead  = ex_ctrl_q.mem_read;
   assign ex_MemWrite = ex_ctrl_q.mem_write;
   assign ex_MemtoReg = ex_ctrl_q.mem_to_reg;
   assign ex_Branch   = ex_ctrl_q.branch;
   assign ex_ALUSrc   = ex_ctrl_q.alu_src;
   assign ex_ALUOp    = ex_ctrl_q.alu_op;

   // Saturating stall-cycle counter: sticks at all-ones instead of wrapping.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_count <= '0;
      end else if (stall && (stall_count != '1)) begin
         stall_count <= stall_count + CNT_W'(1);
      end
   end

   // Saturating flush counter: only real instructions squashed count.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         flush_count <= '0;
      end else if (ex_flush && id_valid && (flush_count != '1)) begin
         flush_count <= flush_count + CNT_W'(1);
      end
   end

endmodule : id_ex_stage

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage. A second instance with 2-bit counters
// sees identical stimulus so counter saturation is reachable in a few edges.
module tb_id_ex_stage;

   logic        clock;
   logic        reset;
   logic        id_valid;
   logic [63:0] id_pc;
   logic [63:0] Read_Data_1;
   logic [63:0] Read_Data_2;
   logic [63:0] id_imm;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic [4:0]  id_rd;
   logic        id_use_rs1;
   logic        id_use_rs2;
   logic [3:0]  id_funct;
   logic        id_RegWrite;
   logic        id_MemRead;
   logic        id_MemWrite;
   logic        id_MemtoReg;
   logic        id_Branch;
   logic        id_ALUSrc;
   logic [1:0]  id_ALUOp;
   logic        wb_RegWrite;
   logic [4:0]  wb_rd;
   logic [63:0] wb_Write_Data;
   logic        ex_flush;

   logic        stall;
   logic        ex_valid;
   logic [63:0] ex_pc;
   logic [63:0] ex_op1;
   logic [63:0] ex_op2;
   logic [63:0] ex_imm;
   logic [4:0]  ex_rs1;
   logic [4:0]  ex_rs2;
   logic [4:0]  ex_rd;
   logic [3:0]  ex_funct;
   logic        ex_RegWrite;
   logic        ex_MemRead;
   logic        ex_MemWrite;
   logic        ex_MemtoReg;
   logic        ex_Branch;
   logic        ex_ALUSrc;
   logic [1:0]  ex_ALUOp;
   logic [31:0] stall_count;
   logic [31:0] flush_count;

   logic        s_stall;
   logic        s_ex_valid;
   logic [63:0] s_ex_pc;
   logic [63:0] s_ex_op1;
   logic [63:0] s_ex_op2;
   logic [63:0] s_ex_imm;
   logic [4:0]  s_ex_rs1;
   logic [4:0]  s_ex_rs2;
   logic [4:0]  s_ex_rd;
   logic [3:0]  s_ex_funct;
   logic        s_ex_RegWrite;
   logic        s_ex_MemRead;
   logic        s_ex_MemWrite;
   logic        s_ex_MemtoReg;
   logic        s_ex_Branch;
   logic        s_ex_ALUSrc;
   logic [1:0]  s_ex_ALUOp;
   logic [1:0]  s_stall_count;
   logic [1:0]  s_flush_count;

   int tests;
   int fails;

   id_ex_stage dut (
      .clock(clock), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
      .Read_Data_1(Read_Data_1), .Read_Data_2(Read_Data_2), .id_imm(id_imm),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_funct(id_funct),
      .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
      .id_MemtoReg(id_MemtoReg), .id_Branch(id_Branch), .id_ALUSrc(id_ALUSrc),
      .id_ALUOp(id_ALUOp), .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd),
      .wb_Write_Data(wb_Write_Data), .ex_flush(ex_flush), .stall(stall),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2),
      .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_funct(ex_funct), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
      .ex_MemWrite(ex_MemWrite), .ex_MemtoReg(ex_MemtoReg), .ex_Branch(ex_Branch),
      .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp), .stall_count(stall_count),
      .flush_count(flush_count)
   );

   id_ex_stage #(.CNT_W(2)) dut_sat (
      .clock(clock), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
      .Read_Data_1(Read_Data_1), .Read_Data_2(Read_Data_2), .id_imm(id_imm),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_funct(id_funct),
      .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
      .id_MemtoReg(id_MemtoReg), .id_Branch(id_Branch), .id_ALUSrc(id_ALUSrc),
      .id_ALUOp(id_ALUOp), .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd),
      .wb_Write_Data(wb_Write_Data), .ex_flush(ex_flush), .stall(s_stall),
      .ex_valid(s_ex_valid), .ex_pc(s_ex_pc), .ex_op1(s_ex_op1), .ex_op2(s_ex_op2),
      .ex_imm(s_ex_imm), .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd),
      .ex_funct(s_ex_funct), .ex_RegWrite(s_ex_RegWrite), .ex_MemRead(s_ex_MemRead),
      .ex_MemWrite(s_ex_MemWrite), .ex_MemtoReg(s_ex_MemtoReg), .ex_Branch(s_ex_Branch),
      .ex_ALUSrc(s_ex_ALUSrc), .ex_ALUOp(s_ex_ALUOp), .stall_count(s_stall_count),
      .flush_count(s_flush_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_nop();
      id_valid = 1'b0; id_pc = '0; Read_Data_1 = '0; Read_Data_2 = '0; id_imm = '0;
      id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      id_funct = '0; id_RegWrite = 1'b0; id_MemRead = 1'b0; id_MemWrite = 1'b0;
      id_MemtoReg = 1'b0; id_Branch = 1'b0; id_ALUSrc = 1'b0; id_ALUOp = 2'b00;
      wb_RegWrite = 1'b0; wb_rd = '0; wb_Write_Data = '0; ex_flush = 1'b0;
   endtask

   // ld x<rd>, 16(x2)
   task automatic issue_load(input logic [4:0] rd, input logic [63:0] pc);
      set_nop();
      id_valid = 1'b1; id_pc = pc; id_rs1 = 5'd2; id_use_rs1 = 1'b1; id_rd = rd;
      id_imm = 64'h10; Read_Data_1 = 64'h1000; id_MemRead = 1'b1; id_MemtoReg = 1'b1;
      id_RegWrite = 1'b1; id_ALUSrc = 1'b1; id_ALUOp = 2'b00; id_funct = 4'b0011;
   endtask

   // add x<rd>, x<rs1>, x<rs2> with chosen use flags
   task automatic issue_add(input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic use1, input logic use2,
                            input logic [4:0] rd, input logic [63:0] pc);
      set_nop();
      id_valid = 1'b1; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = use1;
      id_use_rs2 = use2; id_rd = rd; Read_Data_1 = 64'h10; Read_Data_2 = 64'h20;
      id_RegWrite = 1'b1; id_ALUOp = 2'b10; id_funct = 4'b0000;
   endtask

   initial begin
      tests = 0;
      fails = 0;

      // Reset held for three edges with random inputs.
      reset = 1'b0;
      id_valid = 1'b1; id_pc = {$urandom, $urandom};
      Read_Data_1 = {$urandom, $urandom}; Read_Data_2 = {$urandom, $urandom};
      id_imm = {$urandom, $urandom}; id_rs1 = 5'($urandom); id_rs2 = 5'($urandom);
      id_rd = 5'($urandom); id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
      id_funct = 4'($urandom); id_RegWrite = 1'b1; id_MemRead = 1'b1;
      id_MemWrite = 1'b1; id_MemtoReg = 1'b1; id_Branch = 1'b1; id_ALUSrc = 1'b1;
      id_ALUOp = 2'b11; wb_RegWrite = 1'b1; wb_rd = 5'($urandom);
      wb_Write_Data = {$urandom, $urandom}; ex_flush = 1'($urandom);
      repeat (3) tick();
      check("rst_ex_valid", ex_valid, 0);
      check("rst_ex_pc", ex_pc, 0);
      check("rst_ex_op1", ex_op1, 0);
      check("rst_ex_op2", ex_op2, 0);
      check("rst_ex_imm", ex_imm, 0);
      check("rst_ex_rd", ex_rd, 0);
      check("rst_ex_funct", ex_funct, 0);
      check("rst_ctrl", {ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_Branch, ex_ALUSrc, ex_ALUOp}, 0);
      check("rst_stall", stall, 0);
      check("rst_stall_count", stall_count, 0);
      check("rst_flush_count", flush_count, 0);

      // Release; first instruction with rs1 bypassed from WB.
      set_nop();
      reset = 1'b1;
      id_valid = 1'b1; id_pc = 64'h100; id_rs1 = 5'd5; Read_Data_1 = 64'h11;
      id_rs2 = 5'd6; Read_Data_2 = 64'h22; id_imm = 64'h8; id_rd = 5'd3;
      id_funct = 4'b1000; id_RegWrite = 1'b1; id_ALUOp = 2'b10;
      id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
      wb_RegWrite = 1'b1; wb_rd = 5'd5; wb_Write_Data = 64'hAB;
      #1 check("i1_stall", stall, 0);
      tick();
      check("i1_ex_valid", ex_valid, 1);
      check("byp_op1_wb", ex_op1, 64'hAB);
      check("i1_op2_rf", ex_op2, 64'h22);
      check("i1_ex_pc", ex_pc, 64'h100);
      check("i1_ex_imm", ex_imm, 64'h8);
      check("i1_ex_rs", {ex_rs1, ex_rs2, ex_rd}, {5'd5, 5'd6, 5'd3});
      check("i1_ex_funct", ex_funct, 4'b1000);
      check("i1_ctrl", {ex_RegWrite, ex_MemRead, ex_ALUOp}, 4'b1010);

      // x0 never bypasses and always reads zero.
      id_pc = 64'h104; id_rs1 = 5'd0; Read_Data_1 = 64'h55; wb_rd = 5'd0;
      wb_Write_Data = 64'hCD;
      tick();
      check("byp_x0_op1", ex_op1, 0);

      // rs2 bypass, rs1 from the register file.
      id_pc = 64'h108; id_rs1 = 5'd4; Read_Data_1 = 64'h44; id_rs2 = 5'd9;
      Read_Data_2 = 64'h1; wb_rd = 5'd9; wb_Write_Data = 64'h99;
      tick();
      check("byp_op1_rf", ex_op1, 64'h44);
      check("byp_op2_wb", ex_op2, 64'h99);

      // Matching index but no WB write: no bypass.
      wb_RegWrite = 1'b0;
      tick();
      check("byp_op2_nowe", ex_op2, 64'h1);

      // Load-use on rs2: one stall cycle, one bubble, then the add.
      issue_load(5'd7, 64'h200);
      tick();
      check("ld_ex_memread", ex_MemRead, 1);
      issue_add(5'd1, 5'd7, 1'b1, 1'b1, 5'd8, 64'h204);
      #1 check("lu_stall", stall, 1);
      tick();
      check("lu_bubble_valid", ex_valid, 0);
      check("lu_bubble_ctrl", {ex_RegWrite, ex_MemRead, ex_MemtoReg, ex_ALUSrc}, 0);
      check("lu_bubble_pc_hold", ex_pc, 64'h200);
      check("lu_stall_count", stall_count, 1);
      check("lu_stall_cleared", stall, 0);
      tick();
      check("lu_add_valid", ex_valid, 1);
      check("lu_add_pc", ex_pc, 64'h204);
      check("lu_add_rd", ex_rd, 8);
      check("lu_stall_count_2", stall_count, 1);

      // Same pair but rs2 not actually read: no stall.
      issue_load(5'd7, 64'h300);
      tick();
      issue_add(5'd1, 5'd7, 1'b1, 1'b0, 5'd8, 64'h304);
      #1 check("nouse_stall", stall, 0);
      tick();
      check("nouse_valid", ex_valid, 1);
      check("nouse_pc", ex_pc, 64'h304);
      check("nouse_stall_count", stall_count, 1);

      // Hazard plus flush: flush wins, no stall counted.
      issue_load(5'd7, 64'h400);
      tick();
      issue_add(5'd1, 5'd7, 1'b1, 1'b1, 5'd8, 64'h404);
      ex_flush = 1'b1;
      #1 check("fl_stall", stall, 0);
      tick();
      check("fl_valid", ex_valid, 0);
      check("fl_regwrite", ex_RegWrite, 0);
      check("fl_flush_count", flush_count, 1);
      check("fl_stall_count", stall_count, 1);

      // Flush with an empty ID slot is not counted.
      set_nop();
      ex_flush = 1'b1;
      tick();
      check("fl_empty_valid", ex_valid, 0);
      check("fl_empty_count", flush_count, 1);

      // WB writes the load's rd in the same cycle: still a stall.
      issue_load(5'd7, 64'h500);
      tick();
      issue_add(5'd7, 5'd3, 1'b1, 1'b1, 5'd8, 64'h504);
      wb_RegWrite = 1'b1; wb_rd = 5'd7; wb_Write_Data = 64'h77;
      #1 check("wblu_stall", stall, 1);
      tick();
      check("wblu_bubble", ex_valid, 0);
      check("wblu_stall_count", stall_count, 2);
      check("sat_stall_count_2", s_stall_count, 2'd2);
      tick();
      check("wblu_add_valid", ex_valid, 1);
      check("wblu_op1", ex_op1, 64'h77);

      // Back-to-back dependent loads: exactly one stall cycle.
      issue_load(5'd7, 64'h600);
      tick();
      issue_load(5'd9, 64'h604);
      id_rs1 = 5'd7;
      #1 check("ldld_stall", stall, 1);
      tick();
      check("ldld_bubble", ex_valid, 0);
      check("ldld_stall_count", stall_count, 3);
      check("sat_stall_count_3", s_stall_count, 2'd3);
      check("ldld_stall_cleared", stall, 0);
      tick();
      check("ldld_ld2_valid", ex_valid, 1);
      check("ldld_ld2_rd", ex_rd, 9);
      check("ldld_ld2_memread", ex_MemRead, 1);
      check("ldld_stall_count_2", stall_count, 3);

      // Two more stall events: the 2-bit counter stays at all-ones.
      for (int i = 0; i < 2; i++) begin
         issue_load(5'd7, 64'h700);
         tick();
         issue_add(5'd1, 5'd7, 1'b0, 1'b1, 5'd8, 64'h704);
         tick();
         tick();
      end
      check("stall_count_5", stall_count, 5);
      check("sat_stall_no_wrap", s_stall_count, 2'd3);

      // Three more counted flushes: flush counter saturates too.
      for (int i = 0; i < 3; i++) begin
         set_nop();
         id_valid = 1'b1;
         ex_flush = 1'b1;
         tick();
      end
      ex_flush = 1'b0;
      check("flush_count_4", flush_count, 4);
      check("sat_flush_no_wrap", s_flush_count, 2'd3);

      // Asynchronous reset in the middle of a stall cycle.
      issue_load(5'd7, 64'h800);
      tick();
      issue_add(5'd1, 5'd7, 1'b1, 1'b1, 5'd8, 64'h804);
      #1 check("ar_stall_before", stall, 1);
      #2 reset = 1'b0;
      #1;
      check("ar_stall", stall, 0);
      check("ar_valid", ex_valid, 0);
      check("ar_pc", ex_pc, 0);
      check("ar_memread", ex_MemRead, 0);
      check("ar_rd", ex_rd, 0);
      check("ar_stall_count", stall_count, 0);
      check("ar_flush_count", flush_count, 0);
      tick();
      check("ar_hold_valid", ex_valid, 0);
      reset = 1'b1;
      issue_add(5'd1, 5'd2, 1'b1, 1'b1, 5'd8, 64'h900);
      tick();
      check("ar_post_valid", ex_valid, 1);
      check("ar_post_pc", ex_pc, 64'h900);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_id_ex_stage

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline stage directly downstream of the 64-bit register file in the 5-stage RV64 pipeline.
- Captures the register-file read data, immediate, register indices and decoded control into the ID/EX register.
- Resolves the same-cycle WB-write/ID-read conflict with a bypass.
- Detects load-use hazards and drives a stall, handles branch flush by inserting bubbles, and keeps saturating stall/flush event counters.

Parameters:
- XLEN, 64, datapath width.
- REG_AW, 5, register index width.
- CNT_W, 32, width of the stall and flush event counters.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID slot holds a real instruction.
- id_pc  in  XLEN  PC of the ID instruction.
- Read_Data_1  in  XLEN  register file port 1 data.
- Read_Data_2  in  XLEN  register file port 2 data.
- id_imm  in  XLEN  sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  REG_AW  register indices.
- id_use_rs1, id_use_rs2  in  1  instruction actually reads rs1 / rs2.
- id_funct  in  4  {funct7[5], funct3}.
- id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg, id_Branch, id_ALUSrc  in  1  decoded control.
- id_ALUOp  in  2  ALU operation class.
- wb_RegWrite  in  1  WB stage register write enable (same signals that drive the register file).
- wb_rd  in  REG_AW  WB destination index.
- wb_Write_Data  in  XLEN  WB write data.
- ex_flush  in  1  taken branch/jump resolved in EX; squash the ID instruction.
- stall  out  1  hold PC and IF/ID this cycle.
- ex_valid  out  1  EX slot holds a real instruction.
- ex_pc, ex_op1, ex_op2, ex_imm  out  XLEN  registered PC, operands and immediate.
- ex_rs1, ex_rs2, ex_rd  out  REG_AW  registered register indices.
- ex_funct  out  4  registered funct field.
- ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_Branch, ex_ALUSrc  out  1  registered control.
- ex_ALUOp  out  2  registered ALU operation class.
- stall_count, flush_count  out  CNT_W  saturating event counters.

Behaviour:
- Reset (reset=0, asynchronous): every registered output and both counters go to 0. stall therefore reads 0 while reset is held.
- Latency: 1 cycle, ID inputs to ex_* outputs.
- Operand bypass (combinational, ahead of the register):
  - op1 = 0 if id_rs1==0.
  - Otherwise op1 = wb_Write_Data if wb_RegWrite && wb_rd==id_rs1.
  - Otherwise op1 = Read_Data_1.
  - op2 follows the same rule using id_rs2 and Read_Data_2.
- Load-use hazard: hz = id_valid && ex_valid && ex_MemRead && ex_rd!=0 && ((id_use_rs1 && ex_rd==id_rs1) || (id_use_rs2 && ex_rd==id_rs2)).
- stall = hz && !ex_flush. Combinational; depends only on registered ex_* state and current ID inputs.
- Each rising clock edge, one update in this priority:
  1. Flush (ex_flush=1): bubble.
  2. Stall (stall=1): bubble. The ID instruction stays in IF/ID and re-presents next cycle, and the hazard has cleared by then.
  3. id_valid=0: bubble.
  4. Otherwise load all ex_* from ID (op1/op2 bypassed) and set ex_valid=1.
- Bubble: ex_valid and all six control bits and ex_ALUOp go to 0. ex_pc, ex_op*, ex_imm, ex_rs*, ex_rd and ex_funct hold their previous values. Downstream stages ignore them because ex_valid=0.
- stall_count increments on each edge where stall=1. flush_count increments on each edge where ex_flush=1 && id_valid=1. Both saturate at all-ones with no wrap.
- Simultaneous flush and hazard: flush wins, stall stays 0, no stall count.
- Simultaneous WB write to rd and load-use on the same rd: the bypass applies only to WB; the stall still fires.
- Back-to-back loads: a second load depending on the first stalls exactly one cycle.
- Reset asserted mid-stall: stall drops immediately and the bubble state is held until release.

Decomposition:
- Shared package/include pipe_defs: XLEN, REG_AW, ALUOp encodings (00 load/store add, 01 branch sub, 10 R-type, 11 I-type), funct encodings. Also used by decode and the ALU control block.
- One sub-module, id_hazard_unit: purely combinational operand bypass mux plus load-use detect. id_ex_stage instantiates it and owns the pipeline register and the counters.

Test Plan:
- Reset: reset=0 for 3 cycles with random inputs -> all ex_* = 0, stall = 0, counters = 0. After release, the first valid ID instruction appears on the following edge.
- Bypass: id_rs1=5, Read_Data_1=0x11, wb_RegWrite=1, wb_rd=5, wb_Write_Data=0xAB -> ex_op1=0xAB next cycle. Repeating with id_rs1=0 and wb_rd=0 -> ex_op1=0.
- Load-use: ld x7 (ex_MemRead=1, ex_rd=7) followed by add with id_rs2=7 and id_use_rs2=1 -> stall=1 for exactly 1 cycle, a bubble with ex_valid=0, then the add with ex_valid=1. stall_count=1. With id_use_rs2=0 -> no stall.
- Flush priority: same hazard plus ex_flush=1 -> stall=0, ex_valid=0 next cycle, flush_count=1, stall_count unchanged.
- Saturation: preload the counters to 0xFFFFFFFE and apply 3 stall edges -> stall_count = 0xFFFFFFFF, with no wrap.
- Async reset mid-stall: assert reset between clock edges during a stall -> outputs clear without waiting for a clock edge.
